// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit.
// Operation encodings follow the EX-stage decode; iteration count equals operand width.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;
  localparam int MULDIV_ITERS = MULDIV_WIDTH;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_if.sv
// EX-stage <-> muldiv_unit signal bundle; master is the pipeline, slave is the unit.
// No handshake of its own: the unit answers back-pressure through stall.
interface muldiv_if import muldiv_pkg::*; #(
  parameter int WIDTH = MULDIV_WIDTH
) ();

  logic             op_valid;
  muldiv_op_t       op;
  logic [WIDTH-1:0] rsData;
  logic [WIDTH-1:0] rtData;
  logic             flush;
  logic             mf_req;
  logic             mf_sel;
  logic [WIDTH-1:0] mf_data;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op, rsData, rtData, flush, mf_req, mf_sel,
    input  mf_data, busy, stall, hi, lo
  );

  modport slave (
    input  op_valid, op, rsData, rtData, flush, mf_req, mf_sel,
    output mf_data, busy, stall, hi, lo
  );

endinterface

// File: rtl/muldiv_iter_core.sv
// Radix-2 shift/add multiply and restoring divide on unsigned magnitudes, one bit per step.
// Latency: WIDTH step cycles after start; no back-pressure, the owner sequences start/step.
module muldiv_iter_core import muldiv_pkg::*; #(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               last_iter
);

  localparam int CW = $clog2(MULDIV_ITERS);

  // upper = accumulator / partial remainder, lower = multiplier / quotient
  logic [WIDTH-1:0] upper;
  logic [WIDTH-1:0] lower;
  logic [WIDTH-1:0] operand;
  logic [CW-1:0]    count;
  logic             div_mode;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    add_sum = {1'b0, upper} + (lower[0] ? {1'b0, operand} : '0);
    shifted = {upper, lower[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, operand};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upper    <= '0;
      lower    <= '0;
      operand  <= '0;
      count    <= '0;
      div_mode <= 1'b0;
    end else if (start) begin
      div_mode <= is_div;
      count    <= '0;
      upper    <= '0;
      lower    <= is_div ? opa : opb;
      operand  <= is_div ? opb : opa;
    end else if (step) begin
      count <= count + 1'b1;
      if (div_mode) begin
        // a zero divisor always "fits", yielding all-ones quotient and the dividend as remainder
        if (!trial[WIDTH+1]) begin
          upper <= trial[WIDTH-1:0];
          lower <= {lower[WIDTH-2:0], 1'b1};
        end else begin
          upper <= shifted[WIDTH-1:0];
          lower <= {lower[WIDTH-2:0], 1'b0};
        end
      end else begin
        upper <= add_sum[WIDTH:1];
        lower <= {add_sum[0], lower[WIDTH-1:1]};
      end
    end
  end

  assign product   = {upper, lower};
  assign quotient  = lower;
  assign remainder = upper;
  assign last_iter = (count == CW'(MULDIV_ITERS - 1));

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: FSM, sign handling, HI/LO registers and pipeline stall.
// Latency: 34 edges accept-to-HI/LO; holds EX with stall while busy and a HI/LO user is present.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);

  muldiv_state_t    state;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             div_q;
  logic             neg_q;
  logic             neg_r;

  logic             busy;
  logic             accept;
  logic             start;
  logic             signed_op;
  logic             div_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic               last_iter;

  always_comb begin
    busy      = (state != IDLE);
    accept    = bus.op_valid & ~bus.flush & ~busy;
    signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    div_op    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    start     = accept & ((bus.op == OP_MULT) || (bus.op == OP_MULTU) || div_op);
    a_neg     = signed_op & bus.rsData[WIDTH-1];
    b_neg     = signed_op & bus.rtData[WIDTH-1];
    // -2^(WIDTH-1) stays as its unsigned magnitude
    abs_a     = a_neg ? -bus.rsData : bus.rsData;
    abs_b     = b_neg ? -bus.rtData : bus.rtData;
  end

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .step      (state == RUN),
    .is_div    (div_op),
    .opa       (abs_a),
    .opb       (abs_b),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder),
    .last_iter (last_iter)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hi_q  <= '0;
      lo_q  <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (bus.op)
              OP_MTHI: hi_q <= bus.rsData;
              OP_MTLO: lo_q <= bus.rsData;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state <= RUN;
                div_q <= div_op;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
              end
              default: ;
            endcase
          end
        end
        RUN: if (last_iter) state <= FIX;
        FIX: begin
          state <= IDLE;
          if (div_q) begin
            lo_q <= neg_q ? -quotient  : quotient;
            hi_q <= neg_r ? -remainder : remainder;
          end else begin
            {hi_q, lo_q} <= neg_q ? -product : product;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.stall   = ~bus.flush & busy & ((bus.op_valid & (bus.op != OP_NONE)) | bus.mf_req);
  assign bus.mf_data = bus.mf_sel ? hi_q : lo_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for results/latency plus stall, flush and reset sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy_n;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  int total = 0;
  int bad   = 0;
  int nb, ns;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic issue(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.op       = o;
    bus.rsData   = a;
    bus.rtData   = b;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    bus.op       = OP_NONE;
  endtask

  // Returns at the first falling edge where busy is low; counts busy and stall cycles before it.
  task automatic wait_idle(input string tag, output int nbusy, output int nstall);
    bit done;
    done   = 1'b0;
    nbusy  = 0;
    nstall = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        done = 1'b1;
        break;
      end
      nbusy++;
      if (bus.stall) nstall++;
    end
    chk({tag, "_idle_timeout"}, 32'(done), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[4]  = '{OP_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 33};
    vecs[5]  = '{OP_MTHI,  32'hCAFEBABE, 32'h00000000, 32'hCAFEBABE, 32'hFFFFFFFF, 0};
    vecs[6]  = '{OP_MTLO,  32'h12345678, 32'h00000000, 32'hCAFEBABE, 32'h12345678, 0};
    vecs[7]  = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 33};
    vecs[8]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vecs[9]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'h00000001, 33};
    vecs[10] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
    vecs[11] = '{OP_MULTU, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800, 33};
    vecs[12] = '{OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 33};

    bus.op_valid = 1'b0;
    bus.op       = OP_NONE;
    bus.rsData   = '0;
    bus.rtData   = '0;
    bus.flush    = 1'b0;
    bus.mf_req   = 1'b0;
    bus.mf_sel   = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.mf_req = 1'b1;
    bus.mf_sel = 1'b0;
    @(negedge clk);
    chk("rst_mflo", bus.mf_data, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    bus.mf_sel = 1'b1;
    #1 chk("rst_mfhi", bus.mf_data, 32'h0);
    bus.mf_req = 1'b0;

    // reset in the middle of RUN abandons the operation
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_hi", bus.hi, 32'h0);
    chk("midrst_lo", bus.lo, 32'h0);

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle($sformatf("v%0d", i), nb, ns);
      chk($sformatf("v%0d_busy_cycles", i), 32'(nb), 32'(vecs[i].busy_n));
      chk($sformatf("v%0d_hi", i), bus.hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), bus.lo, vecs[i].lo);
      bus.mf_req = 1'b1;
      bus.mf_sel = 1'b1;
      #1 chk($sformatf("v%0d_mfhi", i), bus.mf_data, vecs[i].hi);
      chk($sformatf("v%0d_idle_stall", i), 32'(bus.stall), 32'd0);
      bus.mf_sel = 1'b0;
      #1 chk($sformatf("v%0d_mflo", i), bus.mf_data, vecs[i].lo);
      bus.mf_req = 1'b0;
    end

    // MFHI one cycle after a MULTU accept stalls until the result lands
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    bus.mf_req = 1'b1;
    bus.mf_sel = 1'b1;
    wait_idle("mfhi", nb, ns);
    chk("mfhi_stall_cycles", 32'(ns), 32'd33);
    chk("mfhi_stall_after", 32'(bus.stall), 32'd0);
    chk("mfhi_data", bus.mf_data, 32'hFFFFFFFE);
    bus.mf_req = 1'b0;

    // MULT presented while busy waits, then is accepted on the first idle cycle
    issue(OP_DIVU, 32'h00000064, 32'h00000007);
    bus.op_valid = 1'b1;
    bus.op       = OP_MULT;
    bus.rsData   = 32'hFFFFFFFD;
    bus.rtData   = 32'h00000007;
    wait_idle("held", nb, ns);
    chk("held_stall_cycles", 32'(ns), 32'd33);
    chk("held_stall_after", 32'(bus.stall), 32'd0);
    chk("held_divu_hi", bus.hi, 32'h00000002);
    chk("held_divu_lo", bus.lo, 32'h0000000E);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    bus.op       = OP_NONE;
    wait_idle("held_mult", nb, ns);
    chk("held_mult_busy_cycles", 32'(nb), 32'd33);
    chk("held_mult_hi", bus.hi, 32'hFFFFFFFF);
    chk("held_mult_lo", bus.lo, 32'hFFFFFFEB);

    // flush suppresses stall and accept but does not cancel the running op
    issue(OP_MULTU, 32'h00000003, 32'h00000005);
    bus.op_valid = 1'b1;
    bus.op       = OP_MULT;
    bus.rsData   = 32'hFFFFFFFD;
    bus.rtData   = 32'h00000007;
    bus.flush    = 1'b1;
    bus.mf_req   = 1'b1;
    wait_idle("flush", nb, ns);
    chk("flush_stall_cycles", 32'(ns), 32'd0);
    chk("flush_busy_cycles", 32'(nb), 32'd33);
    chk("flush_hi", bus.hi, 32'h00000000);
    chk("flush_lo", bus.lo, 32'h0000000F);
    @(posedge clk);
    @(negedge clk);
    chk("flush_no_accept", 32'(bus.busy), 32'd0);
    chk("flush_lo_kept", bus.lo, 32'h0000000F);
    bus.op_valid = 1'b0;
    bus.op       = OP_NONE;
    bus.flush    = 1'b0;
    bus.mf_req   = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle HI/LO multiply/divide unit beside the EX stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs a radix-2 iterative multiply or restoring divide over 32 cycles.
- Holds the architectural HI/LO registers and reads them out for MFHI/MFLO.
- Raises a pipeline stall while a result is pending and a dependent or conflicting instruction is in EX.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each; iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- op_valid  in  1  EX holds a HI/LO-class instruction this cycle
- op  in  3  muldiv_op_t: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6
- rsData  in  WIDTH  operand A (dividend/multiplicand/MT source)
- rtData  in  WIDTH  operand B (divisor/multiplier)
- flush  in  1  squash the EX instruction this cycle
- mf_req  in  1  MFHI or MFLO in EX this cycle
- mf_sel  in  1  0=LO, 1=HI
- mf_data  out  WIDTH  selected HI/LO, combinational from registers
- busy  out  1  state != IDLE
- stall  out  1  freeze IF/ID/EX; EX re-presents the same instruction
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset, synchronous: state=IDLE, count=0, hi=0, lo=0; busy=0, stall=0. Reset mid-operation abandons the operation with no HI/LO write.
- accept = op_valid & ~flush & ~busy.
- stall = ~flush & busy & ((op_valid & op!=NONE) | mf_req). stall never depends on itself.
- When busy is low, mf_req never stalls, and mf_data reflects hi/lo as they stand at that clock edge.
- MTHI/MTLO when accepted: write rsData to hi or lo at that edge. State stays IDLE.
- States:
  - IDLE -> RUN on an accepted MULT*/DIV* edge. That edge latches abs(A), abs(B) for signed ops (raw values for unsigned), the op, and the result signs; it clears the accumulator and sets count=0.
  - RUN, multiply: if multiplier LSB is 1, add the multiplicand into the upper half of the accumulator. Then shift the {carry, acc, multiplier} right by 1.
  - RUN, divide: shift {rem, quotient} left by 1 and trial-subtract the divisor. If the result is non-negative, keep it and set quotient LSB to 1.
  - RUN increments count each edge. At count==WIDTH-1 the edge goes to FIX (32 RUN edges total).
  - FIX applies sign correction, writes hi/lo, then -> IDLE.
- Latency: 34 edges from the accept edge to the hi/lo update (1 accept + 32 RUN + 1 FIX). busy is high for 33 cycles. A stalled MFHI completes on the first cycle after FIX.
- Sign rules:
  - Product is negated as a full 2*WIDTH value when sign(A)^sign(B).
  - Quotient is negated when sign(A)^sign(B).
  - Remainder takes the sign of A.
- Result mapping: multiply {hi,lo}=product. Divide lo=quotient, hi=remainder.
- Divide by zero, no trap: unsigned gives lo=all-ones, hi=A. Signed gives the same raw iteration results, then sign-fixed.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- All arithmetic is unsigned in the core. abs(-2^WIDTH-1) is held as an unsigned value in WIDTH bits.
- flush while busy does not cancel the ongoing operation; it only suppresses a new accept and stall in that cycle.
- op_valid with op=NONE is ignored.

Decomposition:
- muldiv_pkg holds:
  - typedef enum muldiv_op_t (3 bits)
  - typedef enum muldiv_state_t {IDLE, RUN, FIX}
  - localparam MULDIV_ITERS = WIDTH
- Sub-module muldiv_iter_core: the iteration datapath (accumulator, shift/add, trial-subtract, count). It takes start, is_div, and operands, and outputs raw product/quotient/remainder plus last_iter.
- muldiv_unit keeps the FSM, sign handling, HI/LO registers, and stall logic.

Test Plan:
- Reset: hold rst 2 cycles, then MFLO and MFHI -> mf_data=0, busy=0, stall=0. Assert rst at RUN count=10 -> next cycle busy=0, hi/lo unchanged (0).
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 34 edges hi=0xFFFFFFFE, lo=0x00000001. busy high exactly 33 cycles.
- MULT 0xFFFFFFFD(-3)*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x00001234. MTHI 0xCAFEBABE while idle -> hi=0xCAFEBABE next edge, no stall.
- MFHI issued 1 cycle after a MULTU accept -> stall high for 33 cycles, then mf_data=new hi with stall=0. MULT presented while busy -> stalls, then accepted on the first idle cycle. Same with flush=1 -> no stall, no accept.
